// File: rtl/hdmi_island_pkg.sv
// Shared constants, state type and BCH(64,56)/(32,24) step function for the HDMI data-island path.
package hdmi_island_pkg;

  localparam int SLOT_CLOCKS           = 32;
  localparam int SUBPACKET_DATA_CLOCKS = 28;
  localparam int HEADER_DATA_BITS      = 24;
  localparam int ECC_BITS              = 8;

  localparam logic [HEADER_DATA_BITS-1:0] NULL_HEADER_DEFAULT = 24'h000000;

  typedef enum logic {
    IDLE,
    SEND
  } seqState_e;

  // One message bit into the LSbit-first BCH remainder (G(x) = 1 + x^6 + x^7 + x^8).
  function automatic logic [ECC_BITS-1:0] bchStep(input logic [ECC_BITS-1:0] ecc,
                                                  input logic                dataBit);
    logic feedback;
    feedback = ecc[0] ^ dataBit;
    return (ecc >> 1) ^ (feedback ? 8'h83 : 8'h00);
  endfunction

endpackage

// File: rtl/BchEccDualBitEncoder.sv
// Subpacket parity generator: absorbs two bits per clock (even then odd), then shifts parity out two bits a clock.
module BchEccDualBitEncoder
  import hdmi_island_pkg::*;
(
  input  logic                clock_i,
  input  logic                resetN_i,
  input  logic                isFirstDataClock_i,
  input  logic [1:0]          data_i,
  input  logic [ECC_BITS-1:0] syndrome_i,
  output logic [1:0]          ecc_o
);

  logic [ECC_BITS-1:0] ecc_q, ecc_d;
  logic [4:0]          count_q, count_d;

  always_comb begin
    ecc_d   = ecc_q;
    count_d = count_q;
    if (isFirstDataClock_i) begin
      ecc_d   = bchStep(bchStep(syndrome_i, data_i[0]), data_i[1]);
      count_d = 5'd1;
    end else if (count_q < 5'(SUBPACKET_DATA_CLOCKS)) begin
      ecc_d   = bchStep(bchStep(ecc_q, data_i[0]), data_i[1]);
      count_d = count_q + 5'd1;
    end else begin
      ecc_d   = ecc_q >> 2;
    end
  end

  always_ff @(posedge clock_i or negedge resetN_i) begin
    if (!resetN_i) begin
      ecc_q   <= '0;
      count_q <= '0;
    end else begin
      ecc_q   <= ecc_d;
      count_q <= count_d;
    end
  end

  assign ecc_o = ecc_q[1:0];

endmodule

// File: rtl/bch_ecc_header_encoder.sv
// Header parity generator: absorbs one header bit per clock, then shifts its parity byte out LSbit first.
module bch_ecc_header_encoder
  import hdmi_island_pkg::*;
(
  input  logic                clock_i,
  input  logic                resetN_i,
  input  logic                isFirstDataClock_i,
  input  logic                data_i,
  input  logic [ECC_BITS-1:0] syndrome_i,
  output logic                ecc_o
);

  logic [ECC_BITS-1:0] ecc_q, ecc_d;
  logic [4:0]          count_q, count_d;

  // After HEADER_DATA_BITS absorbed bits the remainder is frozen and only shifted out.
  always_comb begin
    ecc_d   = ecc_q;
    count_d = count_q;
    if (isFirstDataClock_i) begin
      ecc_d   = bchStep(syndrome_i, data_i);
      count_d = 5'd1;
    end else if (count_q < 5'(HEADER_DATA_BITS)) begin
      ecc_d   = bchStep(ecc_q, data_i);
      count_d = count_q + 5'd1;
    end else begin
      ecc_d   = ecc_q >> 1;
    end
  end

  always_ff @(posedge clock_i or negedge resetN_i) begin
    if (!resetN_i) begin
      ecc_q   <= '0;
      count_q <= '0;
    end else begin
      ecc_q   <= ecc_d;
      count_q <= count_d;
    end
  end

  assign ecc_o = ecc_q[0];

endmodule

// File: rtl/data_island_packet_sequencer.sv
// Captures one data-island packet per slot and serialises header, subpackets and their BCH parity
// onto the TERC4 bit lanes over 32 pixel clocks.
module data_island_packet_sequencer
  import hdmi_island_pkg::*;
#(
  parameter bit          SEND_NULL   = 1'b1,
  parameter logic [23:0] NULL_HEADER = NULL_HEADER_DEFAULT
) (
  input  logic         clock,
  input  logic         resetN,
  input  logic         slotStart,
  input  logic         packetValid,
  output logic         packetReady,
  input  logic [23:0]  header,
  input  logic [223:0] subpackets,
  output logic         outValid,
  output logic         isFirstPacketClock,
  output logic         ch0Bit,
  output logic [3:0]   ch1Nibble,
  output logic [3:0]   ch2Nibble,
  output logic         overrun
);

  seqState_e      state_q, state_d;
  logic [4:0]     count_q, count_d;
  logic [23:0]    hdr_q, hdr_d;
  logic [223:0]   sub_q, sub_d;
  logic           overrun_q, overrun_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           ch0_q, ch0_d;
  logic [3:0]     ch1_q, ch1_d;
  logic [3:0]     ch2_q, ch2_d;

  logic           lastClock, canStart, startSlot;
  logic           encFirst, hdrBit, hdrEcc;
  logic [3:0][1:0] subData;
  logic [3:0][1:0] subEcc;

  assign lastClock   = (state_q == SEND) && (count_q == 5'(SLOT_CLOCKS - 1));
  assign canStart    = (state_q == IDLE) || lastClock;
  assign startSlot   = slotStart && canStart && (packetValid || SEND_NULL);
  assign packetReady = resetN && slotStart && packetValid && canStart;

  // Encoder feeds: payload bits while data remains, zero fill while parity drains.
  always_comb begin
    encFirst = (state_q == SEND) && (count_q == 5'd0);
    hdrBit   = 1'b0;
    subData  = '0;
    if (state_q == SEND && count_q < 5'(HEADER_DATA_BITS)) begin
      hdrBit = hdr_q[count_q];
    end
    if (state_q == SEND && count_q < 5'(SUBPACKET_DATA_CLOCKS)) begin
      for (int k = 0; k < 4; k++) begin
        subData[k] = sub_q[56*k + 2*int'(count_q) +: 2];
      end
    end
  end

  bch_ecc_header_encoder uHdrEnc (
    .clock_i            (clock),
    .resetN_i           (resetN),
    .isFirstDataClock_i (encFirst),
    .data_i             (hdrBit),
    .syndrome_i         ({ECC_BITS{1'b0}}),
    .ecc_o              (hdrEcc)
  );

  for (genvar k = 0; k < 4; k++) begin : gSubEnc
    BchEccDualBitEncoder uSubEnc (
      .clock_i            (clock),
      .resetN_i           (resetN),
      .isFirstDataClock_i (encFirst),
      .data_i             (subData[k]),
      .syndrome_i         ({ECC_BITS{1'b0}}),
      .ecc_o              (subEcc[k])
    );
  end

  // A start on the last slot clock chains straight into slot clock 0 of the next packet.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hdr_d     = hdr_q;
    sub_d     = sub_q;
    overrun_d = overrun_q | (slotStart && (state_q == SEND) && !lastClock);
    if (state_q == SEND) begin
      count_d = count_q + 5'd1;
    end
    if (lastClock) begin
      state_d = IDLE;
    end
    if (startSlot) begin
      state_d = SEND;
      count_d = 5'd0;
      hdr_d   = packetValid ? header : NULL_HEADER;
      sub_d   = packetValid ? subpackets : '0;
    end
  end

  always_comb begin
    valid_d = 1'b0;
    first_d = 1'b0;
    ch0_d   = 1'b0;
    ch1_d   = '0;
    ch2_d   = '0;
    if (state_q == SEND) begin
      valid_d = 1'b1;
      first_d = encFirst;
      ch0_d   = (count_q < 5'(HEADER_DATA_BITS)) ? hdrBit : hdrEcc;
      for (int k = 0; k < 4; k++) begin
        ch1_d[k] = (count_q < 5'(SUBPACKET_DATA_CLOCKS)) ? subData[k][0] : subEcc[k][0];
        ch2_d[k] = (count_q < 5'(SUBPACKET_DATA_CLOCKS)) ? subData[k][1] : subEcc[k][1];
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      count_q   <= '0;
      hdr_q     <= '0;
      sub_q     <= '0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      ch0_q     <= 1'b0;
      ch1_q     <= '0;
      ch2_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hdr_q     <= hdr_d;
      sub_q     <= sub_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      ch0_q     <= ch0_d;
      ch1_q     <= ch1_d;
      ch2_q     <= ch2_d;
    end
  end

  assign outValid           = valid_q;
  assign isFirstPacketClock = first_q;
  assign ch0Bit             = ch0_q;
  assign ch1Nibble          = ch1_q;
  assign ch2Nibble          = ch2_q;
  assign overrun            = overrun_q;

endmodule

// File: doc/data_island_packet_sequencer.md
Name: data_island_packet_sequencer

Overview:
- Schedules one HDMI data-island packet (24-bit header, four 56-bit subpackets) across a 32-pixel-clock slot.
- Drives one header ECC encoder and four subpacket ECC encoders (BchEccDualBitEncoder). Muxes payload bits, then parity, onto the TERC4 channel bit lanes.
- Sits between the packet source (FIFO or InfoFrame builder) and the TERC4 encoders, in the pixel clock domain.
- The island timing generator supplies slot-start pulses.

Parameters:
- SEND_NULL, 1: when no packet is pending at slotStart, 1 sends a null packet (all-zero header and subpackets); 0 leaves the slot idle (outValid low).
- NULL_HEADER, 24'h000000: header used for null packets.

Ports:
- clock  in  1  pixel clock
- resetN  in  1  asynchronous active-low reset
- slotStart  in  1  one-clock pulse; a packet slot begins on the next clock
- packetValid  in  1  packet source has a packet on header/subpackets
- packetReady  out  1  one-clock accept strobe (packetValid & slotStart & idle-or-last)
- header  in  24  HB0..HB2, LSbit of HB0 transmitted first
- subpackets  in  224  subpacket k at [56k+55:56k], LSbit first
- outValid  out  1  lanes carry packet data this clock
- isFirstPacketClock  out  1  high on slot clock 0 (lets caller clear ch0 bit3)
- ch0Bit  out  1  header/parity bit for TERC4 channel 0 bit2
- ch1Nibble  out  4  bit k = even bit of subpacket k
- ch2Nibble  out  4  bit k = odd bit of subpacket k
- overrun  out  1  sticky; set when slotStart arrives mid-slot

Behaviour:
- Reset (async assert, sync release): all outputs 0, counter 0, state IDLE, overrun 0, captured packet cleared.
- States:
  - IDLE: wait for slotStart.
  - SEND: slotCount 0..31.
  - On slotStart in IDLE: capture header/subpackets if packetValid (pulse packetReady), else NULL_HEADER/zeros. If !packetValid && !SEND_NULL, stay IDLE.
- SEND sequencing, slot clock n:
  - Subpacket encoder k: data = captured bits [2n+1:2n] for n 0..27, isFirstDataClock = (n==0), data = 2'b00 for n 28..31. Syndrome input tied 0.
  - Header encoder: one bit per clock, isFirst at n==0, data = header[n] for n 0..23, 0 for 24..31.
  - Lanes:
    - n 0..27: ch1Nibble[k]/ch2Nibble[k] = raw data bits.
    - n 28..31: encoder k ecc[0]/ecc[1] (parity byte LSbit first).
    - ch0Bit = header[n] for n 0..23, header parity bit (n-24) for n 24..31.
- Latency: lanes are registered; slot clock 0 appears on outputs 1 clock after the first SEND clock. outValid is high for exactly 32 consecutive clocks per slot.
- Back-to-back: slotStart coincident with n==31 is legal. It captures the next packet and the following clock is n==0 with no gap; the encoders restart via isFirstDataClock.
- slotStart at n 0..30: ignored (current packet completes), overrun set. Cleared only by reset.
- packetValid deasserted mid-slot: no effect (packet already captured).
- Reset mid-slot: lanes drop to 0 immediately, partial packet discarded, packetReady never re-asserted for it.

Decomposition:
- Shared package hdmi_island_pkg:
  - SLOT_CLOCKS=32, SUBPACKET_DATA_CLOCKS=28, HEADER_DATA_BITS=24, ECC_BITS=8
  - state typedef {IDLE, SEND}
  - null header constant
- Sub-module bch_ecc_header_encoder: single-bit-per-clock header parity generator, same step function and polynomial as the subpacket encoder. Same first-clock/zero-fill protocol, 1-bit ecc output. The sequencer instantiates it once plus four BchEccDualBitEncoder.

Test Plan:
- Zero packet, SEND_NULL=1: slotStart with packetValid=0 → 32 clocks of outValid=1, all lanes 0, isFirstPacketClock only on the first, packetReady never high.
- Header 24'h0D0282 (AVI InfoFrame header) with AVI payload → ch0Bit clocks 0..23 match header LSbit first; clocks 24..31 match the golden BCH model. ch1/ch2 match the per-subpacket golden parity at 28..31.
- Back-to-back: slotStart at n==31 with packetValid=1 → 64 continuous outValid clocks, second packet's parity is correct (encoders not polluted by first), two packetReady pulses.
- slotStart at n==10 → ignored, first packet unaffected, overrun=1 and stays 1.
- resetN low at n==15 → all outputs 0 asynchronously. Next slotStart after release transmits a full clean 32-clock packet.
- SEND_NULL=0, packetValid=0 at slotStart → outValid stays 0, state remains IDLE.
